// File: rtl/mem_rsp_pkg.sv
// Shared types and helpers for the 1R1W bank responder: the injection entry
// and the bit-masked write merge.
package mem_rsp_pkg;

    localparam int PKG_WIDTH   = 128;
    localparam int PKG_BITADDR = 8;
    localparam int PKG_BITWIDX = 7;

    typedef struct packed {
        logic                   armed;
        logic [PKG_BITADDR-1:0] adr;
        logic [PKG_BITWIDX-1:0] bitIdx;
    } injEntry_t;

    function automatic logic [PKG_WIDTH-1:0] mergeWrite(
        input logic [PKG_WIDTH-1:0] oldWord,
        input logic [PKG_WIDTH-1:0] newWord,
        input logic [PKG_WIDTH-1:0] bitEn
    );
        return (oldWord & ~bitEn) | (newWord & bitEn);
    endfunction

endpackage

// File: rtl/mem_rsp_delay_pipe.sv
// Fixed-latency {vld, data, serr} shift pipeline; every stage advances each
// cycle and an async reset flushes all in-flight entries.
module mem_rsp_delay_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_serr,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data,
    output logic             o_serr
);

    logic             r_vld  [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic             r_serr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i]  <= 1'b0;
                r_data[i] <= '0;
                r_serr[i] <= 1'b0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_data[0] <= i_data;
            r_serr[0] <= i_serr;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
                r_serr[i] <= r_serr[i-1];
            end
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_data = r_data[DEPTH-1];
    assign o_serr = r_serr[DEPTH-1];

endmodule

// File: rtl/mem_1r1w_bank_rsp.sv
// Behavioural 1R1W SRAM bank: bit-masked writes on port A, read-first reads on
// port B returned after SRAM_DELAY cycles, plus one-entry single-bit error injection.
module mem_1r1w_bank_rsp
    import mem_rsp_pkg::*;
#(
    parameter int WIDTH      = PKG_WIDTH,
    parameter int NUMADDR    = 256,
    parameter int BITADDR    = PKG_BITADDR,
    parameter int BITWIDX    = PKG_BITWIDX,
    parameter int SRAM_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               writeA,
    input  logic [BITADDR-1:0] addrA,
    input  logic [WIDTH-1:0]   bwA,
    input  logic [WIDTH-1:0]   dinA,
    input  logic               readB,
    input  logic [BITADDR-1:0] addrB,
    output logic [WIDTH-1:0]   doutB,
    output logic               vldB,
    output logic               serrB,
    input  logic               inj_en,
    input  logic [BITADDR-1:0] inj_adr,
    input  logic [BITWIDX-1:0] inj_bit
);

    // Limits widened by one bit so the range compares also work at full occupancy.
    localparam logic [BITADDR:0] NUM_ADDR_L = NUMADDR[BITADDR:0];
    localparam logic [BITWIDX:0] WIDTH_L    = WIDTH[BITWIDX:0];

    logic [WIDTH-1:0] r_mem [NUMADDR];
    injEntry_t        r_inj;

    logic             w_wrInRange;
    logic             w_rdInRange;
    logic             w_injBitOk;
    logic             w_disarm;
    logic             w_errHit;
    logic [WIDTH-1:0] w_rdWord;
    logic [WIDTH-1:0] w_flipMask;
    logic [WIDTH-1:0] w_rdData;

    assign w_wrInRange = ({1'b0, addrA} < NUM_ADDR_L);
    assign w_rdInRange = ({1'b0, addrB} < NUM_ADDR_L);
    assign w_injBitOk  = ({1'b0, inj_bit} < WIDTH_L);
    assign w_disarm    = writeA && (addrA == r_inj.adr) && bwA[r_inj.bitIdx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUMADDR; i++) begin
                r_mem[i] <= '0;
            end
        end else if (writeA && w_wrInRange) begin
            r_mem[addrA] <= mergeWrite(r_mem[addrA], dinA, bwA);
        end
    end

    // A new injection request takes priority over a disarming write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inj <= '0;
        end else if (inj_en && w_injBitOk) begin
            r_inj.armed  <= 1'b1;
            r_inj.adr    <= inj_adr;
            r_inj.bitIdx <= inj_bit;
        end else if (r_inj.armed && w_disarm) begin
            r_inj.armed <= 1'b0;
        end
    end

    // Read samples the array before this cycle's write lands, giving read-first behaviour.
    always_comb begin
        w_rdWord   = w_rdInRange ? r_mem[addrB] : '0;
        w_errHit   = readB && r_inj.armed && (addrB == r_inj.adr);
        w_flipMask = '0;
        w_flipMask[r_inj.bitIdx] = w_errHit;
        w_rdData   = readB ? (w_rdWord ^ w_flipMask) : '0;
    end

    mem_rsp_delay_pipe #(
        .DEPTH (SRAM_DELAY),
        .WIDTH (WIDTH)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (readB),
        .i_data (w_rdData),
        .i_serr (w_errHit),
        .o_vld  (vldB),
        .o_data (doutB),
        .o_serr (serrB)
    );

endmodule

// File: tb/tb_mem_1r1w_bank_rsp.sv
// Directed bench for mem_1r1w_bank_rsp with hand-computed expectations.
module tb_mem_1r1w_bank_rsp;

    localparam int W    = 128;
    localparam int NA   = 200;
    localparam int BA   = 8;
    localparam int BX   = 7;
    localparam int D    = 2;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic          clk;
    logic          rst;
    logic          writeA;
    logic [BA-1:0] addrA;
    logic [W-1:0]  bwA;
    logic [W-1:0]  dinA;
    logic          readB;
    logic [BA-1:0] addrB;
    logic [W-1:0]  doutB;
    logic          vldB;
    logic          serrB;
    logic          inj_en;
    logic [BA-1:0] inj_adr;
    logic [BX-1:0] inj_bit;

    int checkCount = 0;
    int passCount  = 0;

    mem_1r1w_bank_rsp #(
        .WIDTH      (W),
        .NUMADDR    (NA),
        .BITADDR    (BA),
        .BITWIDX    (BX),
        .SRAM_DELAY (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .writeA  (writeA),
        .addrA   (addrA),
        .bwA     (bwA),
        .dinA    (dinA),
        .readB   (readB),
        .addrB   (addrB),
        .doutB   (doutB),
        .vldB    (vldB),
        .serrB   (serrB),
        .inj_en  (inj_en),
        .inj_adr (inj_adr),
        .inj_bit (inj_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic writeRow(input logic [BA-1:0] a, input logic [W-1:0] d,
                            input logic [W-1:0] bw);
        writeA = 1'b1;
        addrA  = a;
        dinA   = d;
        bwA    = bw;
        stepCycle();
        writeA = 1'b0;
    endtask

    // Issue one read and check the result when it emerges D cycles later.
    task automatic readCheck(input string tag, input logic [BA-1:0] a,
                             input logic [W-1:0] expData, input logic expSerr);
        readB = 1'b1;
        addrB = a;
        stepCycle();
        readB = 1'b0;
        repeat (D - 1) stepCycle();
        checkOutput({tag, "_vld"}, W'(vldB), W'(1'b1));
        checkOutput({tag, "_data"}, doutB, expData);
        checkOutput({tag, "_serr"}, W'(serrB), W'(expSerr));
    endtask

    function automatic logic [W-1:0] streamVal(input int i);
        return {32'(i + 1), 64'h0, 32'hFACE_0000 + 32'(i)};
    endfunction

    task automatic applyStimulus();
        // Reset state
        rst = 1'b1; writeA = 1'b0; addrA = '0; bwA = '0; dinA = '0;
        readB = 1'b0; addrB = '0; inj_en = 1'b0; inj_adr = '0; inj_bit = '0;
        repeat (2) stepCycle();
        checkOutput("rst_vld", W'(vldB), '0);
        checkOutput("rst_dout", doutB, '0);
        checkOutput("rst_serr", W'(serrB), '0);
        rst = 1'b0;
        stepCycle();

        // Full-word write then read next cycle
        writeRow(8'd3, {16{8'hA5}}, ONES);
        readCheck("fullwr", 8'd3, {16{8'hA5}}, 1'b0);

        // Partial bit-write
        writeRow(8'd7, ONES, ONES);
        writeRow(8'd7, '0, W'(8'h0F));
        readCheck("bitwr", 8'd7, {ONES[W-1:4], 4'h0}, 1'b0);

        // Same-cycle read and write returns old data
        writeRow(8'd5, W'(8'h55), ONES);
        writeA = 1'b1; addrA = 8'd5; dinA = W'(16'h1234); bwA = ONES;
        readB = 1'b1; addrB = 8'd5;
        stepCycle();
        writeA = 1'b0; readB = 1'b0;
        repeat (D - 1) stepCycle();
        checkOutput("rdfirst_vld", W'(vldB), W'(1'b1));
        checkOutput("rdfirst_data", doutB, W'(8'h55));
        readCheck("rdafter", 8'd5, W'(16'h1234), 1'b0);

        // Injection on a zero row, persistent across reads
        inj_en = 1'b1; inj_adr = 8'd9; inj_bit = 7'd0;
        stepCycle();
        inj_en = 1'b0;
        readCheck("inj1", 8'd9, W'(1), 1'b1);
        readCheck("inj2", 8'd9, W'(1), 1'b1);
        readCheck("inj_other", 8'd3, {16{8'hA5}}, 1'b0);
        writeRow(8'd9, W'(12'hABC), ONES);
        readCheck("disarm", 8'd9, W'(12'hABC), 1'b0);

        // Disarming write with a same-cycle read still flags the error
        inj_en = 1'b1; inj_adr = 8'd9; inj_bit = 7'd4;
        stepCycle();
        inj_en = 1'b0;
        writeA = 1'b1; addrA = 8'd9; dinA = W'(12'h777); bwA = W'(8'h10);
        readB = 1'b1; addrB = 8'd9;
        stepCycle();
        writeA = 1'b0; readB = 1'b0;
        repeat (D - 1) stepCycle();
        checkOutput("disarm_same_data", doutB, W'(12'hAAC));
        checkOutput("disarm_same_serr", W'(serrB), W'(1'b1));
        readCheck("disarm_after", 8'd9, W'(12'hABC), 1'b0);

        // Injection wins over a simultaneous disarming write
        inj_en = 1'b1; inj_adr = 8'd9; inj_bit = 7'd1;
        writeA = 1'b1; addrA = 8'd9; dinA = '0; bwA = ONES;
        stepCycle();
        inj_en = 1'b0; writeA = 1'b0;
        readCheck("injwins", 8'd9, W'(2), 1'b1);
        writeRow(8'd9, W'(3'h7), W'(2'h2));
        readCheck("injwins_clr", 8'd9, W'(2), 1'b0);

        // Back-to-back stream of 20 reads
        for (int i = 0; i < 20; i++) writeRow(8'(10 + i), streamVal(i), ONES);
        for (int k = 0; k < 20 + D - 1; k++) begin
            readB = (k < 20);
            addrB = 8'(10 + k);
            stepCycle();
            if (k < D - 1) begin
                checkOutput($sformatf("strm_pre%0d", k), W'(vldB), '0);
            end else begin
                checkOutput($sformatf("strm_vld%0d", k), W'(vldB), W'(1'b1));
                checkOutput($sformatf("strm_dat%0d", k), doutB, streamVal(k - D + 1));
            end
        end
        readB = 1'b0;

        // Reset in the middle of a stream
        for (int k = 0; k < 5; k++) begin
            readB = 1'b1;
            addrB = 8'(10 + k);
            stepCycle();
        end
        rst = 1'b1;
        readB = 1'b0;
        #1;
        checkOutput("midrst_vld", W'(vldB), '0);
        checkOutput("midrst_dout", doutB, '0);
        stepCycle();
        rst = 1'b0;
        for (int k = 0; k < D + 1; k++) begin
            stepCycle();
            checkOutput($sformatf("postrst_vld%0d", k), W'(vldB), '0);
        end
        readCheck("postrst_r10", 8'd10, '0, 1'b0);
        readCheck("postrst_r3", 8'd3, '0, 1'b0);

        // Out-of-range write and read
        writeRow(8'(NA), ONES, ONES);
        readCheck("oor", 8'(NA), '0, 1'b0);
        readCheck("oor_r0", 8'd0, '0, 1'b0);
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_1r1w_bank_rsp.md
# mem_1r1w_bank_rsp

Behavioural responder for one physical 1R1W SRAM bank on the t1 memory interface. It accepts port-A writes (bit-write-enabled) and port-B reads from the multiport algorithm top, and returns read data after exactly SRAM_DELAY cycles. It includes a single-entry error-injection register that drives serrB, so the algorithm top's error and forwarding paths can be exercised. One instance is placed per bank in the bank-level test harness.

## Interface
- WIDTH, 128, physical word width (PHYWDTH of the bank)
- NUMADDR, 256, number of rows (NUMSROW)
- BITADDR, 8, row address width
- BITWIDX, 7, bit-index width for injection (ceil log2 WIDTH)
- SRAM_DELAY, 2, read latency in cycles; must be ≥ 1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- writeA  in  1  write strobe
- addrA  in  BITADDR  write row address
- bwA  in  WIDTH  per-bit write enable
- dinA  in  WIDTH  write data
- readB  in  1  read strobe
- addrB  in  BITADDR  read row address
- doutB  out  WIDTH  read data, SRAM_DELAY cycles after readB
- vldB  out  1  doutB qualifier
- serrB  out  1  injected single-bit error flag, aligned with doutB
- inj_en  in  1  arm error injection
- inj_adr  in  BITADDR  row to corrupt
- inj_bit  in  BITWIDX  bit to invert

## Operation
- Array: NUMADDR × WIDTH. Cleared to 0 on rst.
- Write (writeA=1, addrA<NUMADDR):
  - at the clock edge, mem[addrA] = (mem & ~bwA) | (dinA & bwA).
  - addrA ≥ NUMADDR: write dropped.
- Read (readB=1): the array is sampled combinationally in the issue cycle, before that cycle's write.
  - Same-cycle read and write to the same address therefore returns old data (read-first).
  - addrB ≥ NUMADDR returns 0 with vldB=1.
- Injection register {armed, adr, bit}:
  - inj_en=1 with inj_bit<WIDTH loads the register and sets armed.
  - inj_bit ≥ WIDTH is ignored.
  - A reload overwrites any existing entry.
- While armed, any read of adr returns the sampled word with bit `bit` inverted and serrB=1. The stored array content is not modified. Multiple reads each report the error.
- Disarm: a write to adr with bwA[bit]=1 clears armed.
  - Disarm takes effect at the edge, so a same-cycle read of adr still reports the error.
  - Simultaneous inj_en and disarming write: injection wins, register is loaded and armed.
- Read pipeline: SRAM_DELAY stages of {vld, data, serr}.
  - Issue cycle loads stage 1; each stage shifts every cycle.
  - There is no stall or backpressure. Reads may issue every cycle.
- Non-valid outputs: doutB=0, serrB=0 whenever vldB=0.

## Timing
- Reset values: doutB=0, vldB=0, serrB=0, armed=0, array=0. Pipeline contents are flushed.
- rst asserted mid-operation: in-flight reads are discarded. No vldB in the cycles after rst deasserts until a new readB propagates.
- Read latency: readB at cycle T → vldB/doutB/serrB at T+SRAM_DELAY, all registered outputs.
- Write visibility: writeA at T → visible to reads issued at T+1 or later.
- Back-to-back reads at T and T+1 → results at T+D and T+D+1, with no bubble.

## Structure
- Package mem_rsp_pkg: typedef for the injection-entry struct {armed, adr, bit}; function for the masked-write merge.
- Sub-module mem_rsp_delay_pipe: a parameterised {vld, data, serr} shift pipeline with depth SRAM_DELAY and async-reset valid bits. It is reusable for other latency models.
- Top-level: array, write merge, injection register, read sample, pipe instance.

## Test plan
- Full-word write 0xA5…A5 to row 3 at T; read row 3 at T+1 (D=2) → vldB=1 and doutB=0xA5…A5 at T+3, serrB=0.
- Write 0xFF…FF to row 7, then write 0x00 with bwA=0x0F → subsequent read returns 0xFF…F0.
- Same-cycle write 0x1234 and read of row 5 (row previously 0x55) → returns 0x55; read at the next cycle returns 0x1234.
- inj_en with adr 9, bit 0 on a row containing 0 → every read returns 0x1 with serrB=1. A write to row 9 with bwA[0]=1 clears it; the next read returns the written value with serrB=0.
- Reads every cycle for 20 cycles on incrementing addresses → 20 consecutive vldB pulses in order. Assert rst mid-stream → vldB=0 immediately, array reads back 0.
- addrA=addrB=NUMADDR (out of range) → write has no effect; read returns 0 with vldB=1.
